// File: rtl/apb_global_pkg.sv
// Shared APB types and defaults: requester FSM states, captured command
// attributes and the slave-index width helper.
package apb_global_pkg;

  localparam int APB_DEF_NO_OF_SLAVES  = 4;
  localparam int APB_DEF_ADDRESS_WIDTH = 32;
  localparam int APB_DEF_DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  // Width-independent part of a captured command; address, data and strobes
  // are sized by the instantiating module.
  typedef struct packed {
    logic       write;
    logic [2:0] prot;
  } apb_cmd_attr_t;

  // Bits needed to index n slaves (at least one).
  function automatic int apb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Address-to-slave decoder: each slave owns a 2^SLAVE_ADDR_BITS byte window
// starting at address 0. Purely combinational.
module apb_slave_decoder
  import apb_global_pkg::*;
#(
  parameter int NO_OF_SLAVES    = APB_DEF_NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH   = APB_DEF_ADDRESS_WIDTH,
  parameter int SLAVE_ADDR_BITS = 12
) (
  input  logic [ADDRESS_WIDTH-1:0]                       addr_i,
  output logic [NO_OF_SLAVES-1:0]                        sel_o,
  output logic [apb_idx_width(NO_OF_SLAVES)-1:0]         idx_o,
  output logic                                           hit_o
);

  localparam int IDX_W = apb_idx_width(NO_OF_SLAVES);

  logic [ADDRESS_WIDTH-1:0] win;

  assign win   = addr_i >> SLAVE_ADDR_BITS;
  assign hit_o = (win < ADDRESS_WIDTH'(NO_OF_SLAVES));
  assign idx_o = win[IDX_W-1:0];

  // One-hot select; all zero when the address falls outside every window.
  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (hit_o && (win == ADDRESS_WIDTH'(i))) sel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_multi_slave_requester.sv
// APB4 requester for NO_OF_SLAVES completers. Turns a valid/ready command
// stream into SETUP/ACCESS transfers and returns a valid/ready completion.
// Optional feature: define APB_REQUESTER_TIMEOUT_EN to abort ACCESS phases
// that last TIMEOUT_CYCLES cycles without pready.
module apb_multi_slave_requester
  import apb_global_pkg::*;
#(
  parameter int NO_OF_SLAVES    = APB_DEF_NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH   = APB_DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = APB_DEF_DATA_WIDTH,
  parameter int SLAVE_ADDR_BITS = 12
`ifdef APB_REQUESTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 16
`endif
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDRESS_WIDTH-1:0]           req_addr,
  input  logic                               req_write,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [DATA_WIDTH/8-1:0]            req_strb,
  input  logic [2:0]                         req_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_slverr,
  output logic                               rsp_timeout,
  output logic [NO_OF_SLAVES-1:0]            pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDRESS_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [2:0]                         pprot,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata
);

  localparam int IDX_W  = apb_idx_width(NO_OF_SLAVES);
  localparam int STRB_W = DATA_WIDTH / 8;

  apb_req_state_e           state_q, state_d;
  apb_cmd_attr_t            attr_q, attr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]        strb_q, strb_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NO_OF_SLAVES-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_slverr_q, rsp_slverr_d;

  logic [NO_OF_SLAVES-1:0]  dec_sel;
  logic [IDX_W-1:0]         dec_idx;
  logic                     dec_hit;

  logic                     tgt_ready, tgt_err;
  logic [DATA_WIDTH-1:0]    tgt_rdata;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
`endif

  apb_slave_decoder #(
    .NO_OF_SLAVES   (NO_OF_SLAVES),
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .SLAVE_ADDR_BITS(SLAVE_ADDR_BITS)
  ) u_decoder (
    .addr_i(req_addr),
    .sel_o (dec_sel),
    .idx_o (dec_idx),
    .hit_o (dec_hit)
  );

  // Only the addressed slave's response is ever looked at.
  assign tgt_ready = pready[idx_q];
  assign tgt_err   = pslverr[idx_q];
  assign tgt_rdata = prdata[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

  // Next-state and next-datapath logic for the SETUP/ACCESS/RESP sequence.
  always_comb begin
    // NOTE: every target gets its hold value first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d      = state_q;
    attr_d       = attr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef APB_REQUESTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          if (dec_hit) begin
            // Bus fields are only updated for real transfers so that a
            // decode error leaves the pins untouched.
            attr_d  = '{write: req_write, prot: req_prot};
            addr_d  = req_addr;
            wdata_d = req_wdata;
            strb_d  = req_write ? req_strb : '0;
            idx_d   = dec_idx;
            sel_d   = dec_sel;
            state_d = SETUP;
          end else begin
            rsp_rdata_d  = '0;
            rsp_slverr_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      SETUP: begin
`ifdef APB_REQUESTER_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        if (tgt_ready) begin
          rsp_slverr_d = tgt_err;
          rsp_rdata_d  = attr_q.write ? '0 : tgt_rdata;
          state_d      = RESP;
        end
`ifdef APB_REQUESTER_TIMEOUT_EN
        // This cycle's increment would reach the limit: abort now.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by preset.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= IDLE;
      attr_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      attr_q       <= attr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_REQUESTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // req_ready is gated by preset so it reads 0 for the whole reset window.
  assign req_ready  = (state_q == IDLE) && !preset;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign pselx   = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
  assign penable = (state_q == ACCESS);
  assign pwrite  = attr_q.write;
  assign pprot   = attr_q.prot;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  assign pstrb   = strb_q;

endmodule

// File: tb/tb_apb_multi_slave_requester.sv
// Directed bench for apb_multi_slave_requester: a vector table of single
// transfers plus hand-written timeout/wait-forever and reset sequences.
// Builds with or without APB_REQUESTER_TIMEOUT_EN.
module tb_apb_multi_slave_requester;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int EXP_ACC = 16;
`else
  localparam int EXP_ACC = 20;
`endif

  logic            pclk;
  logic            preset;
  logic            req_valid, req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_write;
  logic [DW-1:0]   req_wdata;
  logic [SW-1:0]   req_strb;
  logic [2:0]      req_prot;
  logic            rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr, rsp_timeout;
  logic [NS-1:0]   pselx;
  logic            penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;
  logic [NS-1:0]   pready, pslverr;
  logic [NS*DW-1:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_multi_slave_requester #(
    .NO_OF_SLAVES   (NS),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .SLAVE_ADDR_BITS(12)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_prot   (req_prot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .pselx      (pselx),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    int          hold;
    logic        dec_err;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Target slave is ready (or not) with the given error; every other slave
  // permanently shows ready=1, slverr=1 so a wrong mux select is visible.
  task automatic set_slaves(input logic [3:0] sel, input logic rdy, input logic err);
    pready  = rdy ? 4'hF : ~sel;
    pslverr = ~sel | (err ? sel : 4'h0);
  endtask

  task automatic do_xfer(input int id, input vec_t v);
    string tag;
    int    n_acc;
    logic  bus_ok;
    tag = $sformatf("v%0d", id);
    for (int s = 0; s < NS; s++)
      prdata[s*DW +: DW] = v.exp_sel[s] ? v.rdata : (32'hA5A5_0000 | 32'(s));
    set_slaves(v.exp_sel, 1'b0, v.slverr);
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_prot  = v.prot;
    req_valid = 1'b1;
    check({tag, ".req_ready"}, 128'(req_ready), 128'(1'b1));
    step();
    req_valid = 1'b0;
    if (v.dec_err) begin
      check({tag, ".no_bus"}, 128'({pselx, penable}), 128'(0));
    end else begin
      check({tag, ".setup"},
            128'({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid}),
            128'({v.exp_sel, 1'b0, v.write, v.addr, v.wdata, v.exp_pstrb, v.prot, 1'b0}));
      step();
      n_acc  = 0;
      bus_ok = 1'b1;
      while (n_acc < 40) begin
        n_acc++;
        if (pselx !== v.exp_sel || penable !== 1'b1) bus_ok = 1'b0;
        if (n_acc > v.waits) set_slaves(v.exp_sel, 1'b1, v.slverr);
        step();
        set_slaves(v.exp_sel, 1'b0, v.slverr);
        if (rsp_valid) break;
      end
      check({tag, ".access_cycles"}, 128'(n_acc), 128'(v.waits + 1));
      check({tag, ".access_bus"}, 128'(bus_ok), 128'(1'b1));
      check({tag, ".bus_release"}, 128'({pselx, penable}), 128'(0));
    end
    check({tag, ".resp"},
          128'({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, req_ready}),
          128'({1'b1, v.exp_slverr, 1'b0, v.exp_rdata, 1'b0}));
    // Response must stay put and no command may be taken while it waits.
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      req_addr  = 32'h0;
      req_write = 1'b0;
      step();
      check($sformatf("%s.hold%0d", tag, h),
            128'({rsp_valid, rsp_slverr, rsp_rdata, req_ready, pselx}),
            128'({1'b1, v.exp_slverr, v.exp_rdata, 1'b0, 4'h0}));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, ".handshake"}, 128'({rsp_valid, req_ready}), 128'(2'b01));
  endtask

  task automatic issue_read(input logic [31:0] addr);
    req_addr  = addr;
    req_write = 1'b0;
    req_wdata = 32'h0;
    req_strb  = 4'hF;
    req_prot  = 3'd0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_acc;
    logic [3:0] rst_sel;

    //          addr          wr    wdata         strb  prot  wt slv   rdata         hold dec   sel      pstrb exp_rdata     exp_slv
    vecs[0] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'hBAD0_BAD0, 0, 1'b0, 4'b0010, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_3010, 1'b0, 32'h1111_1111, 4'hF, 3'd2, 2, 1'b0, 32'h1234_5678, 0, 1'b0, 4'b1000, 4'h0, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h0000_5000, 1'b0, 32'h0000_0000, 4'hF, 3'd0, 0, 1'b0, 32'h0000_0000, 0, 1'b1, 4'b0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_2000, 1'b1, 32'hA5A5_5A5A, 4'h5, 3'd5, 1, 1'b1, 32'hBAD0_BAD0, 0, 1'b0, 4'b0100, 4'h5, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0FFC, 1'b0, 32'h0000_0000, 4'hF, 3'd1, 0, 1'b0, 32'hCAFE_F00D, 3, 1'b0, 4'b0001, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{32'h0000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'd0, 0, 1'b0, 32'h0000_0000, 0, 1'b1, 4'b0000, 4'h0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_3FFF, 1'b1, 32'h0000_00C3, 4'h8, 3'd7, 3, 1'b0, 32'hBAD0_BAD0, 0, 1'b0, 4'b1000, 4'h8, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_2008, 1'b0, 32'h0000_0000, 4'hF, 3'd0, 0, 1'b0, 32'h55AA_55AA, 1, 1'b0, 4'b0100, 4'h0, 32'h55AA_55AA, 1'b0};

    preset    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    pready    = '0;
    pslverr   = '0;
    prdata    = '0;

    // Reset: every output low, req_ready rises once preset is released.
    step();
    step();
    check("reset.outputs",
          128'({req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, pselx,
                penable, pwrite, paddr, pwdata, pstrb, pprot}), 128'(0));
    #2 preset = 1'b0;
    step();
    check("reset.req_ready", 128'({req_ready, rsp_valid}), 128'(2'b10));

    for (int i = 0; i < 8; i++) do_xfer(i, vecs[i]);

    // Slave 1 never answers: abort at the limit, or stay in ACCESS without it.
    prdata[1*DW +: DW] = 32'h0BAD_F00D;
    set_slaves(4'b0010, 1'b0, 1'b0);
    issue_read(32'h0000_1000);
    step();
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (penable) n_acc++;
      step();
    end
    check("stall.access_cycles", 128'(n_acc), 128'(EXP_ACC));
`ifdef APB_REQUESTER_TIMEOUT_EN
    check("timeout.resp",
          128'({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata, pselx, penable}),
          128'({1'b1, 1'b1, 1'b1, 32'h0, 4'h0, 1'b0}));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("timeout.handshake", 128'({rsp_valid, req_ready}), 128'(2'b01));

    // pready in the very cycle the count would reach the limit wins.
    issue_read(32'h0000_1000);
    step();
    repeat (15) step();
    set_slaves(4'b0010, 1'b1, 1'b0);
    step();
    set_slaves(4'b0010, 1'b0, 1'b0);
    check("timeout.pready_wins",
          128'({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}),
          128'({1'b1, 1'b0, 1'b0, 32'h0BAD_F00D}));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    set_slaves(4'b0100, 1'b0, 1'b0);
    issue_read(32'h0000_2000);
    step();
    rst_sel = 4'b0100;
`else
    check("stall.still_access", 128'({pselx, penable, rsp_valid}), 128'({4'b0010, 1'b1, 1'b0}));
    rst_sel = 4'b0010;
`endif

    // Reset pulse in the middle of ACCESS.
    check("rst.pre_access", 128'({pselx, penable}), 128'({rst_sel, 1'b1}));
    #2 preset = 1'b1;
    #1;
    check("rst.async_clear", 128'({pselx, penable, req_ready, rsp_valid}), 128'(0));
    #2 preset = 1'b0;
    set_slaves(rst_sel, 1'b1, 1'b0);
    step();
    check("rst.release", 128'({req_ready, rsp_valid, pselx, penable}), 128'({1'b1, 1'b0, 4'h0, 1'b0}));
    step();
    step();
    check("rst.no_response", 128'({rsp_valid, req_ready}), 128'(2'b01));

    do_xfer(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_requester.md
# apb_multi_slave_requester

Parametrised APB4 requester that turns a valid/ready command stream into APB transfers across NO_OF_SLAVES completers. It decodes the target slave from the address, drives the one-hot pselx bus through the SETUP/ACCESS protocol, and muxes per-slave responses. It returns a completion on a valid/ready response channel. It sits between the master-side sequencer/driver logic and the shared apb_if pin bundle, and replaces single-target APB drivers.

## Interface
- NO_OF_SLAVES, 4: number of completers; width of pselx.
- ADDRESS_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: data width; legal values are 8, 16 and 32.
- SLAVE_ADDR_BITS, 12: each slave owns a 2^SLAVE_ADDR_BITS byte window.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles before abort (only with the timeout macro).
- pclk  in  1  APB clock; all logic is on the rising edge.
- preset  in  1  reset, asynchronous and active-high.
- req_valid / req_ready  in / out  1  command handshake.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  byte strobes.
- req_prot  in  3  protection attributes.
- rsp_valid / rsp_ready  out / in  1  completion handshake.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors).
- rsp_slverr  out  1  slave error, decode error or timeout.
- rsp_timeout  out  1  abort caused by timeout.
- pselx  out  NO_OF_SLAVES  one-hot slave select.
- penable, pwrite  out  1  APB control.
- paddr  out  ADDRESS_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pprot  out  3  APB protection.
- pready  in  NO_OF_SLAVES  per-slave ready.
- pslverr  in  NO_OF_SLAVES  per-slave error.
- prdata  in  NO_OF_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. The reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the command and compute idx = req_addr >> SLAVE_ADDR_BITS.
  - If idx < NO_OF_SLAVES, go to SETUP.
  - Otherwise, go to RESP with rsp_slverr=1 and rsp_rdata=0. No APB activity occurs.
- SETUP: pselx[idx]=1, penable=0, paddr/pwrite/pwdata/pprot driven from the captured command. Always lasts exactly one cycle, then ACCESS.
- ACCESS:
  - pselx[idx]=1, penable=1.
  - The block samples only pready[idx], pslverr[idx] and prdata slice idx. Other slaves' inputs are ignored.
  - On pready[idx]=1:
    - Latch rsp_slverr.
    - Latch rsp_rdata: prdata slice for reads, 0 for writes.
    - Go to RESP. pselx and penable drop on the same edge.
- RESP: rsp_valid=1, held with stable data until rsp_ready=1, then IDLE. No new command is accepted in RESP.
- Strobes: pstrb = req_strb for writes and is forced to 0 for reads.
- Output hold: paddr, pwrite, pwdata, pstrb and pprot hold their last values between transfers.
- Reset:
  - Every output is 0 while preset=1, including req_ready and rsp_valid.
  - req_ready rises in the first cycle after preset deasserts.
  - Reset mid-transfer clears pselx and penable immediately, and the in-flight response is discarded.

## Timing
- Command accepted at edge E0. SETUP runs in the E0–E1 cycle, ACCESS starts at E1.
- With zero wait states, pready is sampled at E2 and rsp_valid rises after E2. Accept-to-response latency is 3 cycles.
- Each wait state adds 1 cycle.
- A decode error gives rsp_valid 1 cycle after accept.
- Minimum issue interval is 4 cycles when rsp_ready is tied high.

## Configuration
- APB_REQUESTER_TIMEOUT_EN defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready[idx]=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: pselx and penable drop, and the FSM goes to RESP with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0.
  - If pready arrives in the same cycle the count reaches TIMEOUT_CYCLES, pready wins.
- Macro undefined: no counter, rsp_timeout is tied to 0, and ACCESS waits indefinitely.

## Structure
- apb_global_pkg additions:
  - NO_OF_SLAVES, ADDRESS_WIDTH and DATA_WIDTH defaults.
  - apb_req_state_e enum {IDLE, SETUP, ACCESS, RESP}.
  - A typedef struct for the captured command.
- One sub-module, apb_slave_decoder: combinational addr → {one-hot select, index, hit}. It is reused by the slave-side bench.

## Test plan
- Write to 0x0000_1004 (slave 1), data 0xDEADBEEF, strb 0xF, zero wait:
  - pselx=4'b0010 for 2 cycles, penable high in the second.
  - rsp_valid 3 cycles after accept, rsp_slverr=0.
- Read 0x0000_3010 (slave 3) with pready[3] low for 2 extra cycles, prdata slice 3 = 0x12345678:
  - ACCESS lasts 3 cycles, pstrb=0.
  - rsp_rdata=0x12345678 after 5 cycles.
- Read 0x0000_5000 (idx 5 ≥ 4): pselx stays 0, and rsp_valid rises 1 cycle after accept with rsp_slverr=1.
- Slave 2 returns pslverr=1 with pready: rsp_slverr=1, rsp_timeout=0.
- With the macro defined, pready held 0 for 20 cycles: abort after 16 ACCESS cycles with rsp_slverr=1 and rsp_timeout=1. With the macro undefined, the bus stays in ACCESS.
- preset pulsed during ACCESS, and rsp_ready held 0 for 3 cycles on a normal transfer:
  - After the reset pulse, pselx and penable clear asynchronously, no response is issued, and req_ready=1 one cycle after release.
  - On the held transfer, the response stays stable until the handshake.
